// File: rtl/instr_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit_if
//
// Purpose: groups the instruction-memory read handshake used by the fetch
// unit into a single bundle.
//
// Signals:
//   imem_req   fetch unit -> memory   read request, high for the whole FETCH
//   imem_addr  fetch unit -> memory   6-bit read address, stable while req=1
//   imem_ack   memory -> fetch unit   instruction data valid this cycle
//   imem_data  memory -> fetch unit   16-bit instruction word
//
// Modports:
//   master  the fetch unit (drives req/addr, samples ack/data)
//   slave   the instruction memory (drives ack/data, samples req/addr)
// ---------------------------------------------------------------------------
interface instr_fetch_unit_if;
    logic        imem_req;
    logic [5:0]  imem_addr;
    logic        imem_ack;
    logic [15:0] imem_data;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_data
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_data
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//
// Purpose: control sequencer for a small CPU. It fetches an instruction word
// from instruction memory at the current PC, latches it into an instruction
// register (IR), presents the decoded fields for one cycle, and then executes
// it for exactly one cycle by driving the PC-control code (PS) and the
// register-file write enable. It also supports a halt instruction (resumed
// with run) and a fetch timeout that parks the block in a terminal FAULT state.
//
// Sequence per instruction: FETCH (1+ cycles) -> DECODE (1) -> EXEC (1).
//
// Parameters:
//   HALT_OP      opcode that stops the sequencer in HALT
//   BRZ_OP       branch-if-zero opcode (uses Z during EXEC)
//   JMP_OP       jump-to-register opcode
//   ACK_TIMEOUT  FETCH cycles without imem_ack before entering FAULT
//
// Ports:
//   clk_main   in   sole clock, rising edge
//   reset      in   asynchronous, active-low reset
//   PC         in   current program counter (captured as the fetch address)
//   run        in   start from IDLE / resume from HALT
//   Z          in   datapath zero flag
//   imem       if   instruction memory handshake (master side)
//   PS         out  PC control: 00 hold, 01 increment, 10 branch, 11 jump
//   opcode     out  IR[15:12]
//   DA         out  IR[11:8]
//   SA         out  IR[7:4]
//   SB         out  IR[3:0]
//   reg_we     out  register-file write enable
//   halted     out  high while in HALT
//   fault      out  high while in FAULT
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter logic [3:0] HALT_OP     = 4'hD,
    parameter logic [3:0] BRZ_OP      = 4'hE,
    parameter logic [3:0] JMP_OP      = 4'hF,
    parameter int         ACK_TIMEOUT = 15
) (
    input  logic                      clk_main,
    input  logic                      reset,
    input  logic [5:0]                PC,
    input  logic                      run,
    input  logic                      Z,
    instr_fetch_unit_if.master        imem,
    output logic [1:0]                PS,
    output logic [3:0]                opcode,
    output logic [3:0]                DA,
    output logic [3:0]                SA,
    output logic [3:0]                SB,
    output logic                      reg_we,
    output logic                      halted,
    output logic                      fault
);

    // Wide enough to hold the value ACK_TIMEOUT itself.
    localparam int CNT_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);

    localparam logic [1:0] PS_HOLD   = 2'b00;
    localparam logic [1:0] PS_INC    = 2'b01;
    localparam logic [1:0] PS_BRANCH = 2'b10;
    localparam logic [1:0] PS_JUMP   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_HALT   = 3'd4,
        S_FAULT  = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        ir_q, ir_d;
    logic [CNT_W-1:0]   wait_q, wait_d;
    logic [5:0]         addr_q, addr_d;
    logic [CNT_W-1:0]   wait_inc;
    logic               enter_fetch;

    // State register, instruction register, fetch wait counter and the
    // registered fetch address. Reset is asynchronous so that imem_req
    // (decoded from the state) drops without waiting for a clock edge.
    always_ff @(posedge clk_main or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            ir_q    <= '0;
            wait_q  <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            wait_q  <= wait_d;
            addr_q  <= addr_d;
        end
    end

    // Next-state and output decode. Every path that leads into FETCH only
    // raises enter_fetch; the shared block at the bottom then captures PC as
    // the fetch address and clears the wait counter, so the three entry
    // points (IDLE start, EXEC fall-through, HALT resume) behave identically.
    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        wait_d      = wait_q;
        addr_d      = addr_q;
        PS          = PS_HOLD;
        reg_we      = 1'b0;
        enter_fetch = 1'b0;
        wait_inc    = wait_q + CNT_W'(1);

        unique case (state_q)
            S_IDLE: begin
                if (run) begin
                    enter_fetch = 1'b1;
                end
            end

            S_FETCH: begin
                if (imem.imem_ack) begin
                    ir_d    = imem.imem_data;
                    state_d = S_DECODE;
                end else begin
                    // Count this ack-less cycle; giving up once the count
                    // reaches the limit means exactly ACK_TIMEOUT FETCH
                    // cycles are allowed before FAULT.
                    wait_d = wait_inc;
                    if (wait_inc == CNT_W'(ACK_TIMEOUT)) begin
                        state_d = S_FAULT;
                    end
                end
            end

            S_DECODE: begin
                state_d = S_EXEC;
            end

            S_EXEC: begin
                if (ir_q[15:12] == HALT_OP) begin
                    state_d = S_HALT;
                end else if (ir_q[15:12] == BRZ_OP) begin
                    PS          = Z ? PS_BRANCH : PS_INC;
                    enter_fetch = 1'b1;
                end else if (ir_q[15:12] == JMP_OP) begin
                    PS          = PS_JUMP;
                    enter_fetch = 1'b1;
                end else begin
                    PS          = PS_INC;
                    reg_we      = 1'b1;
                    enter_fetch = 1'b1;
                end
            end

            S_HALT: begin
                // Resuming steps past the halt instruction before refetching.
                if (run) begin
                    PS          = PS_INC;
                    enter_fetch = 1'b1;
                end
            end

            S_FAULT: begin
                state_d = S_FAULT;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (enter_fetch) begin
            state_d = S_FETCH;
            addr_d  = PC;
            wait_d  = '0;
        end
    end

    // The request is purely a decode of the state register, so the async
    // reset clears it immediately; the address register holds it stable.
    assign imem.imem_req  = (state_q == S_FETCH);
    assign imem.imem_addr = addr_q;

    assign opcode = ir_q[15:12];
    assign DA     = ir_q[11:8];
    assign SA     = ir_q[7:4];
    assign SB     = ir_q[3:0];

    assign halted = (state_q == S_HALT);
    assign fault  = (state_q == S_FAULT);

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 The block SHALL have parameter HALT_OP, default 4'hD, halt opcode.
REQ-002 The block SHALL have parameter BRZ_OP, default 4'hE, branch-if-zero opcode.
REQ-003 The block SHALL have parameter JMP_OP, default 4'hF, jump-to-register opcode.
REQ-004 The block SHALL have parameter ACK_TIMEOUT, default 15, maximum FETCH cycles without imem_ack.
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset, with ports as follows.
REQ-006 clk_main  in  1  sole clock; all state changes on its rising edge.
REQ-007 reset  in  1  asynchronous, active-low reset.
REQ-008 PC  in  6  current program counter value.
REQ-009 run  in  1  start from IDLE / resume from HALT.
REQ-010 Z  in  1  datapath zero flag.
REQ-011 imem_ack  in  1  instruction memory data valid.
REQ-012 imem_data  in  16  instruction word {opcode[15:12], DA[11:8], SA[7:4], SB[3:0]}.
REQ-013 imem_req  out  1  instruction read request.
REQ-014 imem_addr  out  6  read address.
REQ-015 PS  out  2  PC control: 00 hold, 01 increment, 10 branch, 11 jump.
REQ-016 opcode, DA, SA, SB  out  4 each  fields of the latched instruction register (IR).
REQ-017 reg_we  out  1  register-file write enable.
REQ-018 halted  out  1  high in HALT.
REQ-019 fault  out  1  high in FAULT.

Function
REQ-020 The FSM SHALL have states IDLE, FETCH, DECODE, EXEC, HALT and FAULT.
REQ-021 IDLE SHALL go to FETCH when run=1; otherwise it stays in IDLE.
REQ-022 On the edge entering FETCH, imem_addr SHALL be registered from PC and then held stable while imem_req=1.
REQ-023 In FETCH, imem_req SHALL be 1.
REQ-024 When imem_ack=1 is sampled in FETCH, IR SHALL be loaded from imem_data and the FSM SHALL go to DECODE; imem_req SHALL be 0 from the next cycle.
REQ-025 imem_ack and imem_data SHALL be ignored outside FETCH.
REQ-026 The FETCH wait counter SHALL clear on FETCH entry and increment each FETCH cycle without ack.
REQ-027 When the FETCH wait counter reaches ACK_TIMEOUT, the FSM SHALL go to FAULT.
REQ-028 FAULT SHALL be terminal until reset, with fault=1, imem_req=0 and PS=00.
REQ-029 DECODE SHALL last one cycle, with IR fields valid on opcode/DA/SA/SB, and SHALL go to EXEC.
REQ-030 EXEC SHALL last exactly one cycle; PS is 00 in every other state and every other cycle except the HALT resume cycle.
REQ-031 In EXEC with opcode==BRZ_OP, Z SHALL be sampled in that cycle: Z=1 gives PS=10, Z=0 gives PS=01; reg_we=0.
REQ-032 In EXEC with opcode==JMP_OP, PS SHALL be 11 and reg_we=0.
REQ-033 In EXEC with opcode==HALT_OP, PS SHALL be 00, reg_we=0, and the next state SHALL be HALT.
REQ-034 In EXEC with any other opcode, PS SHALL be 01 and reg_we=1, for exactly one cycle.
REQ-035 EXEC SHALL go to FETCH, except for HALT_OP.
REQ-036 In HALT, halted SHALL be 1.
REQ-037 In HALT with run=1, PS SHALL be 01 for that single cycle and the next state SHALL be FETCH.
REQ-038 run SHALL be ignored outside IDLE and HALT.
REQ-039 With zero-wait memory (ack in the first FETCH cycle), throughput SHALL be one instruction per 3 cycles: FETCH, DECODE, EXEC.
REQ-040 IR fields SHALL hold their value until the next accepted ack.

Reset
REQ-041 While reset=0, regardless of clock: state IDLE, IR=0, wait counter=0, imem_req=0, imem_addr=0, PS=00, reg_we=0, halted=0, fault=0.
REQ-042 Assertion of reset in any state, including mid-FETCH, SHALL drop imem_req immediately, with no clock required.
REQ-043 After reset deasserts, the block SHALL wait in IDLE for run.

Verification
REQ-044 ALU op: PC=5, run=1, imem_data=16'h1234, ack in first FETCH cycle -> imem_addr=5; opcode=1, DA=2, SA=3, SB=4; PS=01 and reg_we=1 for exactly one cycle; next FETCH 3 cycles after the previous one.
REQ-045 Branch: imem_data=16'hE000 with Z=1 -> PS=10 for one cycle; repeat with Z=0 -> PS=01, reg_we=0.
REQ-046 Jump: imem_data=16'hF300 -> PS=11 for one cycle, reg_we=0, SA output=0.
REQ-047 Halt: imem_data=16'hD000 -> PS stays 00, halted=1 indefinitely; pulse run=1 -> PS=01 for one cycle, halted=0, imem_req=1 next cycle.
REQ-048 Timeout: no ack for 15 FETCH cycles -> fault=1, imem_req=0; a later ack is ignored; reset=0 -> IDLE, fault=0.
REQ-049 Reset mid-wait: reset=0 asynchronously while imem_req=1 with 3-cycle ack latency -> imem_req=0 before the next clock edge, all outputs 0, no IR load.
